// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with address decode, slave timeout and
// a one-cycle completion pulse per master.
module bus_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_byteen,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [3:0]  s_sel,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_byteen,
  output logic        s_we,
  input  logic        s_ready,
  input  logic [31:0] s_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          last_r;
  logic          gnt_r;

  logic          gnt_s;
  logic [31:0]   g_addr_s;
  logic [31:0]   g_wdata_s;
  logic [3:0]    g_byteen_s;
  logic          g_we_s;
  logic [3:0]    dec_s;
  logic          fin_s;
  logic          fin_err_s;
  logic [31:0]   fin_rdata_s;

  // Returns the one-hot slave select, or zero when the access must be rejected.
  function automatic logic [3:0] decode(input logic [31:0] addr, input logic [3:0] be);
    logic [3:0] sel;
    sel = 4'b0000;
    if (be == 4'b0000) begin
      sel = 4'b0000;
    end else if (addr <= 32'h0000_2FFF) begin
      sel = 4'b0001;
    end else if (addr >= 32'h0000_7F00 && addr <= 32'h0000_7F0B) begin
      sel = (be == 4'b1111) ? 4'b0010 : 4'b0000;
    end else if (addr >= 32'h0000_7F10 && addr <= 32'h0000_7F1B) begin
      sel = (be == 4'b1111) ? 4'b0100 : 4'b0000;
    end else if (addr >= 32'h0000_7F20 && addr <= 32'h0000_7F23) begin
      sel = 4'b1000;
    end else begin
      sel = 4'b0000;
    end
    return sel;
  endfunction

  // Grant selection and decode of the winning request.
  always_comb begin
    gnt_s = 1'b0;
    if (m0_req && m1_req) begin
      gnt_s = ~last_r;
    end else begin
      gnt_s = m1_req;
    end
    g_addr_s   = gnt_s ? m1_addr   : m0_addr;
    g_wdata_s  = gnt_s ? m1_wdata  : m0_wdata;
    g_byteen_s = gnt_s ? m1_byteen : m0_byteen;
    g_we_s     = gnt_s ? m1_we     : m0_we;
    dec_s      = decode(g_addr_s, g_byteen_s);
  end

  // Completion of a BUSY cycle; s_ready wins over the timeout on the last cycle.
  always_comb begin
    fin_s       = s_ready || (cnt_r == CW'(TIMEOUT));
    fin_err_s   = 1'b0;
    fin_rdata_s = 32'h0000_0000;
    if (s_ready) begin
      fin_err_s   = 1'b0;
      fin_rdata_s = s_we ? 32'h0000_0000 : s_rdata;
    end else begin
      fin_err_s   = 1'b1;
      fin_rdata_s = 32'h0000_0000;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      last_r   <= 1'b1;
      gnt_r    <= 1'b0;
      m0_ack   <= 1'b0;
      m0_rdata <= 32'h0000_0000;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_rdata <= 32'h0000_0000;
      m1_err   <= 1'b0;
      s_sel    <= 4'b0000;
      s_addr   <= 32'h0000_0000;
      s_wdata  <= 32'h0000_0000;
      s_byteen <= 4'b0000;
      s_we     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt_r  <= gnt_s;
            last_r <= gnt_s;
            if (dec_s != 4'b0000) begin
              state_r  <= BUSY;
              cnt_r    <= CW'(1);
              s_sel    <= dec_s;
              s_addr   <= g_addr_s;
              s_wdata  <= g_wdata_s;
              s_byteen <= g_byteen_s;
              s_we     <= g_we_s;
            end else begin
              state_r <= ERR;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (fin_s) begin
            state_r  <= DONE;
            cnt_r    <= '0;
            s_sel    <= 4'b0000;
            s_addr   <= 32'h0000_0000;
            s_wdata  <= 32'h0000_0000;
            s_byteen <= 4'b0000;
            s_we     <= 1'b0;
            m0_ack   <= ~gnt_r;
            m1_ack   <= gnt_r;
            m0_err   <= ~gnt_r & fin_err_s;
            m1_err   <= gnt_r & fin_err_s;
            m0_rdata <= gnt_r ? 32'h0000_0000 : fin_rdata_s;
            m1_rdata <= gnt_r ? fin_rdata_s : 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ERR: begin
          state_r  <= DONE;
          m0_ack   <= ~gnt_r;
          m1_ack   <= gnt_r;
          m0_err   <= ~gnt_r;
          m1_err   <= gnt_r;
          m0_rdata <= 32'h0000_0000;
          m1_rdata <= 32'h0000_0000;
        end
        DONE: begin
          state_r  <= IDLE;
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          m0_err   <= 1'b0;
          m1_err   <= 1'b0;
          m0_rdata <= 32'h0000_0000;
          m1_rdata <= 32'h0000_0000;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter with hand-written contention
// and reset-in-flight sequences.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  s_sel, s_byteen;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_we, s_ready;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_byteen(m0_byteen),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_byteen(m1_byteen),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
    .s_we(s_we), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          rdy;
    logic [31:0] srd;
    logic [3:0]  esel;
    logic        eerr;
    logic [31:0] erd;
    int          elat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic m, input logic [31:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wdata);
    if (m) begin
      m1_req = 1'b1; m1_addr = addr; m1_we = we; m1_byteen = be; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_addr = addr; m0_we = we; m0_byteen = be; m0_wdata = wdata;
    end
  endtask

  task automatic drop_req(input logic m);
    if (m) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  // Issue one request, serve it as the vector says and check the outcome.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    lat = 0;
    drive_req(v.m, v.addr, v.we, v.be, v.wdata);
    tick();
    // Changing the request fields after the latch must not disturb the transfer.
    if (v.m) m1_addr = ~v.addr;
    else     m0_addr = ~v.addr;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if ((v.m ? m1_ack : m0_ack) === 1'b1) begin
        lat = c;
        chk($sformatf("v%0d_rdata", idx), v.m ? m1_rdata : m0_rdata, v.erd);
        chk($sformatf("v%0d_err", idx), {31'd0, v.m ? m1_err : m0_err}, {31'd0, v.eerr});
        chk($sformatf("v%0d_other_ack", idx), {31'd0, v.m ? m0_ack : m1_ack}, 32'd0);
        chk($sformatf("v%0d_done_sel", idx), {28'd0, s_sel}, 32'd0);
        drop_req(v.m);
        s_ready = 1'b0;
      end else begin
        chk($sformatf("v%0d_sel_c%0d", idx, c), {28'd0, s_sel}, {28'd0, v.esel});
        if (c == 1 && v.esel != 4'b0000) begin
          chk($sformatf("v%0d_s_addr", idx), s_addr, v.addr);
          chk($sformatf("v%0d_s_we", idx), {31'd0, s_we}, {31'd0, v.we});
        end
        s_ready = (c == v.rdy);
        s_rdata = (c == v.rdy) ? v.srd : 32'hBAD0_BAD0;
        tick();
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, v.elat);
    drop_req(v.m);
    s_ready = 1'b0;
    tick();
  endtask

  initial begin
    //          m     addr          we    be       wdata  rdy srd            esel     err   erd          lat
    vecs[0]  = '{1'b0, 32'h0000_0004, 1'b0, 4'b1111, 32'h0, 1, 32'h1234_5678, 4'b0001, 1'b0, 32'h1234_5678, 2};
    vecs[1]  = '{1'b1, 32'h0000_7F01, 1'b1, 4'b0010, 32'h9, 1, 32'h0,         4'b0000, 1'b1, 32'h0,         2};
    vecs[2]  = '{1'b0, 32'h0000_3000, 1'b0, 4'b1111, 32'h0, 1, 32'h7777_7777, 4'b0000, 1'b1, 32'h0,         2};
    vecs[3]  = '{1'b0, 32'h0000_7F24, 1'b0, 4'b1111, 32'h0, 0, 32'h0,         4'b0000, 1'b1, 32'h0,         2};
    vecs[4]  = '{1'b0, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 0, 32'h0,         4'b0001, 1'b1, 32'h0,         9};
    vecs[5]  = '{1'b0, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 8, 32'hA5A5_A5A5, 4'b0001, 1'b0, 32'hA5A5_A5A5, 9};
    vecs[6]  = '{1'b1, 32'h0000_7F14, 1'b0, 4'b1111, 32'h0, 3, 32'h0000_CAFE, 4'b0100, 1'b0, 32'h0000_CAFE, 4};
    vecs[7]  = '{1'b0, 32'h0000_7F20, 1'b1, 4'b0001, 32'h5, 2, 32'hFFFF_FFFF, 4'b1000, 1'b0, 32'h0,         3};
    vecs[8]  = '{1'b1, 32'h0000_2FFF, 1'b0, 4'b1000, 32'h0, 1, 32'h0BAD_F00D, 4'b0001, 1'b0, 32'h0BAD_F00D, 2};
    vecs[9]  = '{1'b0, 32'h0000_7F08, 1'b0, 4'b0000, 32'h0, 1, 32'h0,         4'b0000, 1'b1, 32'h0,         2};
    vecs[10] = '{1'b1, 32'h0000_7F1C, 1'b0, 4'b1111, 32'h0, 1, 32'h0,         4'b0000, 1'b1, 32'h0,         2};

    reset = 1'b1;
    m0_req = 1'b0; m0_addr = 32'h0; m0_we = 1'b0; m0_byteen = 4'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_addr = 32'h0; m1_we = 1'b0; m1_byteen = 4'h0; m1_wdata = 32'h0;
    s_ready = 1'b0; s_rdata = 32'h0;
    tick();
    tick();
    chk("reset_outs", {m0_ack, m0_err, m1_ack, m1_err, s_we, s_sel, s_byteen},
        32'd0);
    chk("reset_data", m0_rdata | m1_rdata | s_addr | s_wdata, 32'd0);
    reset = 1'b0;

    // First contention after reset: M0 wins, then M1 is served.
    drive_req(1'b0, 32'h0000_7F04, 1'b1, 4'b1111, 32'h0000_0011);
    drive_req(1'b1, 32'h0000_7F14, 1'b0, 4'b1111, 32'h0);
    tick();
    chk("c1_sel", {28'd0, s_sel}, 32'h2);
    chk("c1_we", {31'd0, s_we}, 32'd1);
    chk("c1_wdata", s_wdata, 32'h0000_0011);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    chk("c1_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("c1_m1_ack", {31'd0, m1_ack}, 32'd0);
    drop_req(1'b0);
    tick();
    chk("c1_idle_sel", {28'd0, s_sel}, 32'd0);
    tick();
    chk("c2_sel", {28'd0, s_sel}, 32'h4);
    s_ready = 1'b1;
    s_rdata = 32'h5555_AAAA;
    tick();
    s_ready = 1'b0;
    chk("c2_m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("c2_m1_rdata", m1_rdata, 32'h5555_AAAA);
    drop_req(1'b1);
    tick();

    // Solo M0 transfer leaves M0 as last granted; next contention goes to M1.
    run_vec(vecs[0], 0);
    drive_req(1'b0, 32'h0000_7F04, 1'b1, 4'b1111, 32'h0000_0022);
    drive_req(1'b1, 32'h0000_7F14, 0, 4'b1111, 32'h0);
    tick();
    chk("c3_sel", {28'd0, s_sel}, 32'h4);
    s_ready = 1'b1;
    s_rdata = 32'h0000_0042;
    tick();
    s_ready = 1'b0;
    chk("c3_m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("c3_m0_ack", {31'd0, m0_ack}, 32'd0);
    drop_req(1'b1);
    tick();
    tick();
    chk("c4_sel", {28'd0, s_sel}, 32'h2);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    chk("c4_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("c4_m0_rdata", m0_rdata, 32'd0);
    drop_req(1'b0);
    tick();

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while BUSY abandons the transfer with no ack.
    drive_req(1'b0, 32'h0000_0010, 1'b0, 4'b1111, 32'h0);
    tick();
    chk("rb_sel", {28'd0, s_sel}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drop_req(1'b0);
    chk("rb_outs", {m0_ack, m0_err, m1_ack, m1_err, s_we, s_sel, s_byteen}, 32'd0);
    chk("rb_addr", s_addr, 32'd0);
    s_ready = 1'b1;
    tick();
    chk("rb_noack1", {31'd0, m0_ack | m1_ack}, 32'd0);
    tick();
    s_ready = 1'b0;
    chk("rb_noack2", {31'd0, m0_ack | m1_ack}, 32'd0);
    run_vec(vecs[6], 106);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
